// File: rtl/ccff_bitstream_loader.sv
// Source end of the configuration chain. Bitstream bytes arrive over a
// valid/ready stream and are serialised MSB-first onto ccff_head, one bit
// per shift cycle. An optional verify pass compares the bits leaving the
// chain (ccff_tail) against a re-sent copy of the stream.
//
// Handshake: a byte transfers on a rising prog_clk edge where both
// in_valid and in_ready are 1. in_valid must hold in_data stable until that
// edge. in_ready never depends on in_valid.
module ccff_bitstream_loader #(
    parameter int CHAIN_LEN = 28,
    parameter int CNT_W     = 16
) (
    input  logic             prog_clk,
    input  logic             prog_reset,
    input  logic             start,
    input  logic             verify,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             ccff_head,
    output logic             ccff_shift_en,
    input  logic             ccff_tail,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] mismatch_count,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    state_t     state_q;
    state_t     state_d;
    logic [7:0] byte_q;
    logic [2:0] idx_q;
    logic       byte_valid_q;
    logic       vmode_q;
    logic       last_shift;
    logic       accept;

    // Chain-facing outputs decode from registers only.
    assign ccff_shift_en = (state_q == LOAD) && byte_valid_q;
    assign ccff_head     = byte_valid_q & byte_q[7];
    assign last_shift    = ccff_shift_en && (bit_count == LAST_BIT);

    // Refill while empty, or in the cycle the last bit of the current byte
    // shifts (zero-bubble). No refill on the terminating shift: any byte
    // taken then would only be thrown away.
    assign in_ready = (state_q == LOAD) &&
                      (!byte_valid_q ||
                       ((idx_q == 3'd7) && ccff_shift_en && !last_shift));
    assign accept    = in_valid && in_ready;

    assign busy      = (state_q == LOAD);
    assign done      = (state_q == DONE);
    assign dbg_state = state_q;

    // Next-state decode: start only counts in IDLE; DONE lasts one cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    if (last_shift) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) state_q <= IDLE;
        else            state_q <= state_d;
    end

    // Byte buffer, counters and verify compare.
    always_ff @(posedge prog_clk) begin
        if (prog_reset) begin
            byte_q         <= '0;
            idx_q          <= '0;
            byte_valid_q   <= 1'b0;
            vmode_q        <= 1'b0;
            mismatch       <= 1'b0;
            bit_count      <= '0;
            mismatch_count <= '0;
        end else begin
            if ((state_q == IDLE) && start) begin
                vmode_q        <= verify;
                bit_count      <= '0;
                mismatch_count <= '0;
                mismatch       <= 1'b0;
            end
            if (ccff_shift_en) begin
                byte_q    <= {byte_q[6:0], 1'b0};
                idx_q     <= idx_q + 3'd1;
                bit_count <= bit_count + 1'b1;
                if (idx_q == 3'd7) byte_valid_q <= 1'b0;
                // ccff_tail here is the bit leaving before this shift.
                if (vmode_q && (ccff_tail != ccff_head)) begin
                    mismatch <= 1'b1;
                    if (mismatch_count != CNT_MAX)
                        mismatch_count <= mismatch_count + 1'b1;
                end
            end
            if (accept) begin
                byte_q       <= in_data;
                idx_q        <= '0;
                byte_valid_q <= 1'b1;
            end
            // Terminating shift drops whatever is left of the final byte.
            if (last_shift) begin
                byte_q       <= '0;
                idx_q        <= '0;
                byte_valid_q <= 1'b0;
            end
        end
    end

endmodule
